instruction_loader: RTL and testbench
=====================================

# instruction_loader

Boot-time writer for the instruction memory. Accepts a little-endian byte stream (2-byte word-count header followed by the program words), assembles 32-bit instructions and writes them into instruction memory at consecutive word addresses. Holds the core in reset until the whole program has been written. Sits between the host/serial byte source and the instruction memory write port; its `core_reset` output drives the processor's `reset`.

## Interface
- `DEPTH`, 1024: instruction memory capacity in 32-bit words; legal word counts are 0..DEPTH.
- `BASE_ADDRESS`, 64'h0: byte address of the first written word.

- `clock`  in  1  single clock for the block.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; from DONE or ERROR, restarts a load. Ignored in other states.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader can accept a byte; a byte transfers on a cycle with `rx_valid && rx_ready`.
- `im_write_enable`  out  1  one-cycle write strobe to instruction memory.
- `im_write_address`  out  64  byte address, `BASE_ADDRESS + 4*index`.
- `im_write_data`  out  32  assembled instruction.
- `core_reset`  out  1  processor reset; high while loading or on error.
- `done`  out  1  program loaded, core running.
- `error`  out  1  header word count exceeded `DEPTH`.

## Operation
- States: HDR_LO, HDR_HI, WORD, DONE, ERROR. Reset enters HDR_LO.
- HDR_LO: accepted byte -> count[7:0]; go HDR_HI.
- HDR_HI: accepted byte -> count[15:8]. Evaluated on the full 16-bit count: count > DEPTH -> ERROR; count == 0 -> DONE; else WORD with index 0, byte_idx 0.
- WORD: accepted bytes fill the assembly register little-endian (byte_idx 0 -> bits [7:0] ... 3 -> [31:24]). On the 4th byte: register write (data, address for current index), index += 1, byte_idx -> 0; if index+1 == count go DONE, else stay WORD.
- DONE: `rx_ready` 0, `core_reset` 0, `done` 1. `start` -> HDR_LO, `core_reset` 1 again, index cleared.
- ERROR: `rx_ready` 0, `core_reset` 1, `error` 1. Only `start` or `reset` leaves (to HDR_LO).
- `rx_ready` is 1 in HDR_LO, HDR_HI, WORD; 0 in DONE, ERROR.
- Index is a counter of width clog2(DEPTH+1); never wraps because count ≤ DEPTH is enforced. Address arithmetic is 64-bit, `BASE_ADDRESS + (index << 2)`.
- `rx_valid` low mid-word: assembly and byte_idx hold; no timeout.

## Timing
- Reset values: `rx_ready` 0, `im_write_enable` 0, `im_write_address` 0, `im_write_data` 0, `core_reset` 1, `done` 0, `error` 0. All outputs registered.
- `rx_ready` rises on the first clock edge after `reset` deasserts.
- Throughput: one byte per cycle; one word per 4 accepted bytes.
- Write latency: `im_write_enable` high for exactly the cycle following acceptance of a word's 4th byte, address/data valid that cycle.
- Final word: `core_reset` falls and `done` rises one cycle after the last `im_write_enable` cycle (i.e. two edges after the last byte accepted). With continuous `rx_valid`, N words: last byte accepted in cycle 2+4N-1, `done` at cycle 2+4N+1 (cycles counted from first `rx_ready`).
- count == 0: `core_reset` falls, `done` rises on the edge after HDR_HI acceptance; no write strobe.
- ERROR: `error` rises on the edge after HDR_HI acceptance; `rx_ready` falls same edge.
- `start` in DONE/ERROR: `core_reset` 1, `done`/`error` 0, `rx_ready` 1 on next edge.
- `reset` mid-load: immediate return to reset values; partial words discarded; already-written memory not cleared.

## Structure
- Shared package `loader_pkg`: state enum (HDR_LO, HDR_HI, WORD, DONE, ERROR), `HEADER_BYTES = 2`, `WORD_BYTES = 4`.
- One natural sub-module: `loader_word_assembler` (byte_idx counter, 32-bit shift/fill register, word-complete pulse). FSM, index counter and output registers stay in `instruction_loader`.

## Test plan
- Reset then stream 02 00 13 05 10 00 93 05 20 00 continuous -> writes 32'h00100513 @ 0x0, 32'h00200593 @ 0x4; `done` 1 and `core_reset` 0 one cycle after second strobe.
- Same stream with `rx_valid` dropped 3 cycles between bytes 2 and 3 of word 0 -> identical writes, only delayed; no extra strobes.
- Header 00 00 -> no `im_write_enable`; `done` 1 the edge after header; `rx_ready` 0.
- DEPTH=4, header 05 00 -> `error` 1, `core_reset` 1, `rx_ready` 0; following bytes ignored; `start` -> HDR_LO, `rx_ready` 1, `error` 0.
- `reset` asserted after 6 bytes of a 2-word load -> outputs at reset values immediately; reload 01 00 EF BE AD DE -> single write 32'hDEADBEEF @ BASE_ADDRESS.
- From DONE, `start` pulse then header 01 00 + 4 bytes -> `core_reset` re-asserted for the whole load, write lands at index 0 address.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Holds the load FSM state encoding and the byte-stream framing sizes.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        WORD,
        DONE,
        ERROR
    } state_t;

    localparam int HEADER_BYTES = 2;
    localparam int WORD_BYTES   = 4;

    // Byte address of the instruction at word position 'index'.
    function automatic logic [63:0] word_address(input logic [63:0] base, input logic [31:0] index);
        return base + ({32'h0, index} << 2);
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The slave modport is the loader side; master is the host/memory side.
interface instruction_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        im_write_enable;
    logic [63:0] im_write_address;
    logic [31:0] im_write_data;

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, im_write_enable, im_write_address, im_write_data
    );

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, im_write_enable, im_write_address, im_write_data
    );
endinterface

// File: rtl/loader_word_assembler.sv
// Collects accepted stream bytes little-endian into a 32-bit instruction.
// word_complete flags the cycle in which the 4th byte is being accepted.
module loader_word_assembler
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_data,
    output logic        word_complete
);

    logic [1:0] byte_idx_reg;
    logic [7:0] lane_reg [WORD_BYTES-1];

    // Only the first three lanes are stored; the top byte is taken live so the
    // full word is available in the same cycle its last byte arrives.
    for (genvar gi = 0; gi < WORD_BYTES - 1; gi++) begin : g_lane
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                lane_reg[gi] <= 8'h00;
            end else if (byte_valid && !clear && byte_idx_reg == 2'(gi)) begin
                lane_reg[gi] <= byte_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_idx_reg <= 2'd0;
        end else if (clear) begin
            byte_idx_reg <= 2'd0;
        end else if (byte_valid) begin
            byte_idx_reg <= byte_idx_reg + 2'd1;
        end
    end

    assign word_complete = byte_valid && !clear && (byte_idx_reg == 2'(WORD_BYTES - 1));
    assign word_data     = {byte_data, lane_reg[2], lane_reg[1], lane_reg[0]};

endmodule

// File: rtl/instruction_loader.sv
// Boot loader: parses a word-count header, writes the program words into
// instruction memory and keeps the core in reset until the load completes.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int          DEPTH        = 1024,
    parameter logic [63:0] BASE_ADDRESS = 64'h0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    instruction_loader_if.slave  bus,
    output logic                 core_reset,
    output logic                 done,
    output logic                 error
);

    localparam int INDEX_W = $clog2(DEPTH + 1);

    state_t               state_reg;
    logic [15:0]          count_reg;
    logic [INDEX_W-1:0]   index_reg;
    logic                 rx_ready_reg;
    logic                 im_we_reg;
    logic [63:0]          im_addr_reg;
    logic [31:0]          im_data_reg;
    logic                 core_reset_reg;
    logic                 done_reg;
    logic                 error_reg;

    logic                 accept;
    logic [15:0]          hdr_count;
    logic [INDEX_W-1:0]   idx_next;
    logic                 last_word;
    logic [31:0]          word_data;
    logic                 word_complete;

    assign accept    = bus.rx_valid && rx_ready_reg;
    assign hdr_count = {bus.rx_data, count_reg[7:0]};
    assign idx_next  = index_reg + INDEX_W'(1);
    assign last_word = (32'(idx_next) == {16'h0, count_reg});

    loader_word_assembler u_assembler (
        .clock         (clock),
        .reset         (reset),
        .clear         (state_reg != WORD),
        .byte_valid    (accept && state_reg == WORD),
        .byte_data     (bus.rx_data),
        .word_data     (word_data),
        .word_complete (word_complete)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= HDR_LO;
            count_reg      <= 16'h0;
            index_reg      <= '0;
            rx_ready_reg   <= 1'b0;
            im_we_reg      <= 1'b0;
            im_addr_reg    <= 64'h0;
            im_data_reg    <= 32'h0;
            core_reset_reg <= 1'b1;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            im_we_reg <= 1'b0;
            case (state_reg)
                HDR_LO: begin
                    rx_ready_reg <= 1'b1;
                    if (accept) begin
                        count_reg[7:0] <= bus.rx_data;
                        state_reg      <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (accept) begin
                        count_reg <= hdr_count;
                        index_reg <= '0;
                        if (int'({16'h0, hdr_count}) > DEPTH) begin
                            state_reg    <= ERROR;
                            rx_ready_reg <= 1'b0;
                            error_reg    <= 1'b1;
                        end else if (hdr_count == 16'h0) begin
                            state_reg      <= DONE;
                            rx_ready_reg   <= 1'b0;
                            done_reg       <= 1'b1;
                            core_reset_reg <= 1'b0;
                        end else begin
                            state_reg <= WORD;
                        end
                    end
                end
                WORD: begin
                    if (word_complete) begin
                        im_we_reg   <= 1'b1;
                        im_addr_reg <= word_address(BASE_ADDRESS, 32'(index_reg));
                        im_data_reg <= word_data;
                        index_reg   <= idx_next;
                        if (last_word) begin
                            state_reg    <= DONE;
                            rx_ready_reg <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // Release the core one cycle after the final write strobe.
                    done_reg       <= 1'b1;
                    core_reset_reg <= 1'b0;
                    if (start) begin
                        state_reg      <= HDR_LO;
                        index_reg      <= '0;
                        rx_ready_reg   <= 1'b1;
                        done_reg       <= 1'b0;
                        core_reset_reg <= 1'b1;
                    end
                end
                ERROR: begin
                    if (start) begin
                        state_reg    <= HDR_LO;
                        rx_ready_reg <= 1'b1;
                        error_reg    <= 1'b0;
                    end
                end
                default: state_reg <= HDR_LO;
            endcase
        end
    end

    assign bus.rx_ready         = rx_ready_reg;
    assign bus.im_write_enable  = im_we_reg;
    assign bus.im_write_address = im_addr_reg;
    assign bus.im_write_data    = im_data_reg;
    assign core_reset           = core_reset_reg;
    assign done                 = done_reg;
    assign error                = error_reg;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: table of load scenarios plus hand-written
// reset/restart sequences; memory writes are checked against a scoreboard.
module tb_instruction_loader;

    localparam int          DEPTH = 4;
    localparam logic [63:0] BASE  = 64'h0000_0000_8000_1000;

    typedef struct {
        bit               use_reset;
        logic [15:0]      count;
        logic [3:0][31:0] words;
        int               gap_pos;
        int               gap_len;
        int               nsend;
        bit               exp_done;
        bit               exp_error;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic core_reset;
    logic done;
    logic error;

    int   total  = 0;
    int   passed = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vecs[7];
    vec_t hv;

    instruction_loader_if bus();

    instruction_loader #(.DEPTH(DEPTH), .BASE_ADDRESS(BASE)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard: every write strobe must match the oldest pending expectation.
    always @(negedge clock) begin
        if (!reset && bus.im_write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", bus.im_write_enable, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", bus.im_write_address, mon_e.addr);
                check("write_data", bus.im_write_data, mon_e.data);
                $display("write addr=%h data=%h", bus.im_write_address, bus.im_write_data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic set_vec(input int i, input bit use_reset, input logic [15:0] count,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3,
                           input int gap_pos, input int gap_len, input int nsend,
                           input bit exp_done, input bit exp_error);
        vecs[i].use_reset = use_reset;
        vecs[i].count     = count;
        vecs[i].words[0]  = w0;
        vecs[i].words[1]  = w1;
        vecs[i].words[2]  = w2;
        vecs[i].words[3]  = w3;
        vecs[i].gap_pos   = gap_pos;
        vecs[i].gap_len   = gap_len;
        vecs[i].nsend     = nsend;
        vecs[i].exp_done  = exp_done;
        vecs[i].exp_error = exp_error;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check("byte_accepted", bus.rx_ready, 1'b1);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rx_ready_after_reset", bus.rx_ready, 1'b1);
        check("core_reset_after_reset", core_reset, 1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_rx_ready", bus.rx_ready, 1'b1);
        check("start_done", done, 1'b0);
        check("start_error", error, 1'b0);
        check("start_core_reset", core_reset, 1'b1);
    endtask

    task automatic run_load(input vec_t v);
        send_byte(v.count[7:0]);
        send_byte(v.count[15:8]);
        if (v.nsend == 0) begin
            bus.rx_valid = 1'b0;
            check("hdr_done", done, v.exp_done);
            check("hdr_error", error, v.exp_error);
            check("hdr_rx_ready", bus.rx_ready, 1'b0);
        end else begin
            for (int k = 0; k < v.nsend; k++) begin
                for (int b = 0; b < 4; b++) begin
                    if (k == 0 && b == v.gap_pos && v.gap_len > 0) begin
                        bus.rx_valid = 1'b0;
                        repeat (v.gap_len) @(negedge clock);
                    end
                    if (b == 3) exp_q.push_back('{BASE + 64'(k) * 64'd4, v.words[k]});
                    send_byte(v.words[k][8*b +: 8]);
                end
            end
            bus.rx_valid = 1'b0;
            check("last_strobe", bus.im_write_enable, 1'b1);
            check("done_in_strobe_cycle", done, 1'b0);
            check("core_reset_in_strobe_cycle", core_reset, 1'b1);
            @(negedge clock);
            check("done_after_strobe", done, 1'b1);
            check("core_reset_after_strobe", core_reset, 1'b0);
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        set_vec(0, 1, 16'd2, 32'h00100513, 32'h00200593, 32'h0, 32'h0, 0, 0, 2, 1, 0);
        set_vec(1, 0, 16'd2, 32'h00100513, 32'h00200593, 32'h0, 32'h0, 2, 3, 2, 1, 0);
        set_vec(2, 0, 16'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1, 0);
        set_vec(3, 0, 16'd4, 32'hDEADBEEF, 32'h00000001, 32'h80000000, 32'hFFFFFFFF, 0, 0, 4, 1, 0);
        set_vec(4, 0, 16'd5, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 1);
        set_vec(5, 0, 16'h0100, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 1);
        set_vec(6, 0, 16'd1, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 0, 0, 1, 1, 0);

        #2 reset = 1'b1;
        #1;
        check("rst_rx_ready", bus.rx_ready, 1'b0);
        check("rst_we", bus.im_write_enable, 1'b0);
        check("rst_addr", bus.im_write_address, 64'h0);
        check("rst_data", bus.im_write_data, 32'h0);
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].use_reset) do_reset();
            else pulse_start();
            run_load(vecs[i]);
            // Bytes offered after the load finishes must be ignored.
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'h5A;
            repeat (3) @(negedge clock);
            bus.rx_valid = 1'b0;
            check("end_done", done, vecs[i].exp_done);
            check("end_error", error, vecs[i].exp_error);
            check("end_core_reset", core_reset, !vecs[i].exp_done);
            check("end_rx_ready", bus.rx_ready, 1'b0);
            check("writes_drained", 64'(exp_q.size()), 64'd0);
            $display("vector %0d count=%0d done=%0b error=%0b", i, vecs[i].count, done, error);
        end

        // Reset mid-load: one full word plus one byte of a second word.
        do_reset();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h93);
        send_byte(8'h05);
        send_byte(8'h20);
        exp_q.push_back('{BASE, 32'h00200593});
        send_byte(8'h00);
        send_byte(8'h13);
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_rx_ready", bus.rx_ready, 1'b0);
        check("midrst_we", bus.im_write_enable, 1'b0);
        check("midrst_addr", bus.im_write_address, 64'h0);
        check("midrst_data", bus.im_write_data, 32'h0);
        check("midrst_core_reset", core_reset, 1'b1);
        check("midrst_done", done, 1'b0);
        check("midrst_error", error, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_rx_ready_back", bus.rx_ready, 1'b1);
        hv = vecs[6];
        hv.words[0] = 32'hDEADBEEF;
        run_load(hv);
        check("midrst_writes_drained", 64'(exp_q.size()), 64'd0);
        $display("reset-mid-load reload done=%0b", done);

        // Restart from DONE: core held in reset for the whole reload.
        pulse_start();
        send_byte(8'h01);
        check("reload_core_reset_hdr_lo", core_reset, 1'b1);
        send_byte(8'h00);
        check("reload_core_reset_hdr_hi", core_reset, 1'b1);
        send_byte(8'hC0);
        send_byte(8'hFF);
        send_byte(8'hEE);
        check("reload_core_reset_b2", core_reset, 1'b1);
        exp_q.push_back('{BASE, 32'h11EEFFC0});
        send_byte(8'h11);
        bus.rx_valid = 1'b0;
        check("reload_strobe", bus.im_write_enable, 1'b1);
        check("reload_core_reset_strobe", core_reset, 1'b1);
        @(negedge clock);
        check("reload_core_reset_released", core_reset, 1'b0);
        check("reload_done", done, 1'b1);
        check("reload_writes_drained", 64'(exp_q.size()), 64'd0);
        $display("restart-from-done reload done=%0b", done);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
